// File: rtl/dds_seq_pkg.sv
// Shared types and helpers for the DDS update sequencer and its per-channel handshake.
package dds_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PAR_WAIT,
        SEQ_LAUNCH,
        SEQ_WAIT,
        FINISH
    } seq_state_t;

    typedef enum logic [1:0] {
        CH_IDLE,
        CH_REQ,
        CH_BUSY
    } ch_state_t;

    localparam logic MODE_PARALLEL   = 1'b0;
    localparam logic MODE_SEQUENTIAL = 1'b1;

    // Ceiling log2, never below 1 so that single-entry selectors still have a bit.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/dds_ch_handshake.sv
// Update/busy handshake for one ad9914_ctrl: raises update, waits for busy to rise and fall,
// and reports completion or a per-phase timeout through a one-cycle fin pulse.
module dds_ch_handshake
    import dds_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic i_go,
    input  logic i_busy,
    output logic o_update,
    output logic o_fin,
    output logic o_ok
);

    localparam int CNT_W = clog2(TIMEOUT_CYCLES);

    ch_state_t        r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic             r_update, w_update_next;
    logic             r_fin, w_fin_next;
    logic             r_ok, w_ok_next;
    logic             w_at_limit;

    assign w_at_limit = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= CH_IDLE;
            r_cnt    <= '0;
            r_update <= 1'b0;
            r_fin    <= 1'b0;
            r_ok     <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_update <= w_update_next;
            r_fin    <= w_fin_next;
            r_ok     <= w_ok_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_update_next = r_update;
        w_fin_next    = 1'b0;
        w_ok_next     = 1'b0;
        case (r_state)
            CH_IDLE: begin
                if (i_go) begin
                    w_update_next = 1'b1;
                    w_cnt_next    = '0;
                    w_state_next  = CH_REQ;
                end
            end
            CH_REQ: begin
                if (i_busy) begin
                    w_update_next = 1'b0;
                    w_cnt_next    = '0;
                    w_state_next  = CH_BUSY;
                end else if (w_at_limit) begin
                    w_update_next = 1'b0;
                    w_fin_next    = 1'b1;
                    w_state_next  = CH_IDLE;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            CH_BUSY: begin
                // Busy falling takes priority over a timeout landing on the same cycle.
                if (!i_busy) begin
                    w_fin_next   = 1'b1;
                    w_ok_next    = 1'b1;
                    w_state_next = CH_IDLE;
                end else if (w_at_limit) begin
                    w_update_next = 1'b0;
                    w_fin_next    = 1'b1;
                    w_state_next  = CH_IDLE;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_update_next = 1'b0;
                w_state_next  = CH_IDLE;
            end
        endcase
    end

    assign o_update = r_update;
    assign o_fin    = r_fin;
    assign o_ok     = r_ok;

endmodule

// File: rtl/dds_update_sequencer.sv
// Shadow/active sweep-configuration banks plus a launch FSM that runs the per-channel
// update handshakes either all at once or one channel at a time, lowest index first.
module dds_update_sequencer
    import dds_seq_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int FTW_WIDTH      = 32,
    parameter int RATE_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cfg_wr,
    input  logic [clog2(NUM_CH)-1:0]       cfg_ch,
    input  logic [FTW_WIDTH-1:0]           cfg_lower,
    input  logic [FTW_WIDTH-1:0]           cfg_upper,
    input  logic [FTW_WIDTH-1:0]           cfg_step,
    input  logic [RATE_WIDTH-1:0]          cfg_rate,
    input  logic                           start,
    input  logic                           mode,
    input  logic [NUM_CH-1:0]              ch_enable,
    output logic [NUM_CH-1:0]              ch_update,
    input  logic [NUM_CH-1:0]              ch_busy,
    output logic [NUM_CH*FTW_WIDTH-1:0]    lower_limit,
    output logic [NUM_CH*FTW_WIDTH-1:0]    upper_limit,
    output logic [NUM_CH*FTW_WIDTH-1:0]    positive_step,
    output logic [NUM_CH*RATE_WIDTH-1:0]   positive_rate,
    output logic                           busy,
    output logic                           done,
    output logic [NUM_CH-1:0]              ch_ok,
    output logic [NUM_CH-1:0]              ch_err
);

    localparam int CH_W = clog2(NUM_CH);

    seq_state_t          r_state, w_state_next;
    logic                r_busy, w_busy_next;
    logic                r_done, w_done_next;
    logic [NUM_CH-1:0]   r_en, w_en_next;
    logic [NUM_CH-1:0]   r_ok, w_ok_next;
    logic [NUM_CH-1:0]   r_err, w_err_next;
    logic [NUM_CH-1:0]   r_go, w_go_next;
    logic [CH_W-1:0]     r_cur, w_cur_next;

    logic [NUM_CH-1:0]   w_fin, w_fin_ok;
    logic [NUM_CH-1:0]   w_pending, w_lowest;
    logic [CH_W-1:0]     w_lowest_idx;

    logic [FTW_WIDTH-1:0]  r_sh_lower [NUM_CH];
    logic [FTW_WIDTH-1:0]  r_sh_upper [NUM_CH];
    logic [FTW_WIDTH-1:0]  r_sh_step  [NUM_CH];
    logic [RATE_WIDTH-1:0] r_sh_rate  [NUM_CH];
    logic [FTW_WIDTH-1:0]  r_act_lower[NUM_CH];
    logic [FTW_WIDTH-1:0]  r_act_upper[NUM_CH];
    logic [FTW_WIDTH-1:0]  r_act_step [NUM_CH];
    logic [RATE_WIDTH-1:0] r_act_rate [NUM_CH];

    // go is registered, so the copy below sees a shadow write made alongside start.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (rst) begin
                r_sh_lower[i]  <= '0;
                r_sh_upper[i]  <= '0;
                r_sh_step[i]   <= '0;
                r_sh_rate[i]   <= '0;
                r_act_lower[i] <= '0;
                r_act_upper[i] <= '0;
                r_act_step[i]  <= '0;
                r_act_rate[i]  <= '0;
            end else begin
                if (cfg_wr && (cfg_ch == CH_W'(i))) begin
                    r_sh_lower[i] <= cfg_lower;
                    r_sh_upper[i] <= cfg_upper;
                    r_sh_step[i]  <= cfg_step;
                    r_sh_rate[i]  <= cfg_rate;
                end
                if (r_go[i]) begin
                    r_act_lower[i] <= r_sh_lower[i];
                    r_act_upper[i] <= r_sh_upper[i];
                    r_act_step[i]  <= r_sh_step[i];
                    r_act_rate[i]  <= r_sh_rate[i];
                end
            end
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        dds_ch_handshake #(
            .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
        ) u_hs (
            .clk      (clk),
            .rst      (rst),
            .i_go     (r_go[gi]),
            .i_busy   (ch_busy[gi]),
            .o_update (ch_update[gi]),
            .o_fin    (w_fin[gi]),
            .o_ok     (w_fin_ok[gi])
        );

        assign lower_limit[gi*FTW_WIDTH +: FTW_WIDTH]     = r_act_lower[gi];
        assign upper_limit[gi*FTW_WIDTH +: FTW_WIDTH]     = r_act_upper[gi];
        assign positive_step[gi*FTW_WIDTH +: FTW_WIDTH]   = r_act_step[gi];
        assign positive_rate[gi*RATE_WIDTH +: RATE_WIDTH] = r_act_rate[gi];
    end

    assign w_pending = r_en & ~(r_ok | r_err);
    assign w_lowest  = w_pending & (~w_pending + NUM_CH'(1));

    always_comb begin
        w_lowest_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_pending[i]) begin
                w_lowest_idx = CH_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_en    <= '0;
            r_ok    <= '0;
            r_err   <= '0;
            r_go    <= '0;
            r_cur   <= '0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
            r_en    <= w_en_next;
            r_ok    <= w_ok_next;
            r_err   <= w_err_next;
            r_go    <= w_go_next;
            r_cur   <= w_cur_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_busy_next  = r_busy;
        w_done_next  = 1'b0;
        w_en_next    = r_en;
        w_go_next    = '0;
        w_cur_next   = r_cur;
        // Only launched channels can produce fin, so status is recorded unconditionally.
        w_ok_next    = r_ok | (w_fin & w_fin_ok);
        w_err_next   = r_err | (w_fin & ~w_fin_ok);
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_en_next   = ch_enable;
                    w_ok_next   = '0;
                    w_err_next  = '0;
                    w_busy_next = 1'b1;
                    if (ch_enable == '0) begin
                        w_state_next = FINISH;
                    end else if (mode == MODE_PARALLEL) begin
                        w_go_next    = ch_enable;
                        w_state_next = PAR_WAIT;
                    end else begin
                        w_state_next = SEQ_LAUNCH;
                    end
                end
            end
            PAR_WAIT: begin
                if (((w_ok_next | w_err_next) & r_en) == r_en) begin
                    w_state_next = FINISH;
                end
            end
            SEQ_LAUNCH: begin
                if (w_pending == '0) begin
                    w_state_next = FINISH;
                end else begin
                    w_go_next    = w_lowest;
                    w_cur_next   = w_lowest_idx;
                    w_state_next = SEQ_WAIT;
                end
            end
            SEQ_WAIT: begin
                if (w_fin[r_cur]) begin
                    w_state_next = SEQ_LAUNCH;
                end
            end
            FINISH: begin
                w_done_next  = 1'b1;
                w_busy_next  = 1'b0;
                w_state_next = IDLE;
            end
            default: begin
                w_busy_next  = 1'b0;
                w_state_next = IDLE;
            end
        endcase
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign ch_ok  = r_ok;
    assign ch_err = r_err;

endmodule

// File: tb/tb_dds_update_sequencer.sv
// Scoreboard bench for dds_update_sequencer: a per-channel busy responder plus
// expected status/active-bank queues filled at launch and drained after each done.
`timescale 1ns/1ps
module tb_dds_update_sequencer;
    import dds_seq_pkg::*;

    localparam int NUM_CH         = 4;
    localparam int FTW_WIDTH      = 32;
    localparam int RATE_WIDTH     = 16;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int CH_W           = 2;
    localparam int ACT_W          = 3 * FTW_WIDTH + RATE_WIDTH;

    logic                         clk = 1'b0;
    logic                         rst = 1'b1;
    logic                         cfg_wr = 1'b0;
    logic [CH_W-1:0]              cfg_ch = '0;
    logic [FTW_WIDTH-1:0]         cfg_lower = '0, cfg_upper = '0, cfg_step = '0;
    logic [RATE_WIDTH-1:0]        cfg_rate = '0;
    logic                         start = 1'b0;
    logic                         mode = 1'b0;
    logic [NUM_CH-1:0]            ch_enable = '0;
    logic [NUM_CH-1:0]            ch_update;
    logic [NUM_CH-1:0]            ch_busy;
    logic [NUM_CH*FTW_WIDTH-1:0]  lower_limit, upper_limit, positive_step;
    logic [NUM_CH*RATE_WIDTH-1:0] positive_rate;
    logic                         busy, done;
    logic [NUM_CH-1:0]            ch_ok, ch_err;

    dds_update_sequencer #(
        .NUM_CH(NUM_CH), .FTW_WIDTH(FTW_WIDTH),
        .RATE_WIDTH(RATE_WIDTH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
        .cfg_lower(cfg_lower), .cfg_upper(cfg_upper), .cfg_step(cfg_step), .cfg_rate(cfg_rate),
        .start(start), .mode(mode), .ch_enable(ch_enable),
        .ch_update(ch_update), .ch_busy(ch_busy),
        .lower_limit(lower_limit), .upper_limit(upper_limit),
        .positive_step(positive_step), .positive_rate(positive_rate),
        .busy(busy), .done(done), .ch_ok(ch_ok), .ch_err(ch_err)
    );

    always #5 clk = ~clk;

    typedef struct packed { int ch; logic [ACT_W-1:0] val; } act_t;
    typedef struct packed { logic [NUM_CH-1:0] ok; logic [NUM_CH-1:0] err; } stat_t;
    act_t  sb_act[$];
    stat_t sb_stat[$];

    int n_cmp = 0;
    int n_err = 0;

    // Shadow-bank reference model
    logic [FTW_WIDTH-1:0]  m_lower[NUM_CH], m_upper[NUM_CH], m_step[NUM_CH];
    logic [RATE_WIDTH-1:0] m_rate[NUM_CH];

    // Busy responder: rises dly cycles after update is seen, stays high len cycles.
    int t[NUM_CH];
    int dly[NUM_CH];
    int len[NUM_CH];
    bit stuck[NUM_CH];

    always @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (rst) begin
                t[i] <= -1;
                ch_busy[i] <= 1'b0;
            end else if (t[i] < 0) begin
                if (ch_update[i] && !stuck[i]) begin
                    t[i] <= 1;
                    ch_busy[i] <= (dly[i] <= 1);
                end
            end else if (t[i] + 1 >= dly[i] + len[i]) begin
                t[i] <= -1;
                ch_busy[i] <= 1'b0;
            end else begin
                t[i] <= t[i] + 1;
                ch_busy[i] <= (t[i] + 1 >= dly[i]);
            end
        end
    end

    // Observations gathered by observe(); compared by the individual tests.
    int                 rise_cyc[NUM_CH];
    int                 hi_cnt[NUM_CH];
    int                 drop_viol[NUM_CH];
    logic [ACT_W-1:0]   act_at_rise[NUM_CH];
    logic [NUM_CH-1:0]  okv_at_rise[NUM_CH];
    int                 done_cnt, done_cyc, max_ones;
    logic [NUM_CH-1:0]  ok_at_done, err_at_done;
    logic               busy_at_done;

    task automatic cfg_write(input int ch, input logic [31:0] lo, input logic [31:0] up,
                             input logic [31:0] st, input logic [15:0] rt);
        @(negedge clk);
        cfg_wr = 1'b1; cfg_ch = CH_W'(ch);
        cfg_lower = lo; cfg_upper = up; cfg_step = st; cfg_rate = rt;
        m_lower[ch] = lo; m_upper[ch] = up; m_step[ch] = st; m_rate[ch] = rt;
        @(negedge clk);
        cfg_wr = 1'b0;
    endtask

    task automatic push_expect(input logic [NUM_CH-1:0] en, input logic [NUM_CH-1:0] ok,
                               input logic [NUM_CH-1:0] err);
        for (int i = 0; i < NUM_CH; i++) begin
            if (en[i]) sb_act.push_back('{ch: i, val: {m_lower[i], m_upper[i], m_step[i], m_rate[i]}});
        end
        sb_stat.push_back('{ok: ok, err: err});
    endtask

    task automatic launch(input logic m, input logic [NUM_CH-1:0] en);
        @(negedge clk);
        mode = m; ch_enable = en; start = 1'b1;
        $display("launch mode=%0d en=%b", m, en);
    endtask

    task automatic observe(input int budget, input int restart_at, input int cfg_at,
                           input logic [31:0] cfg_val);
        logic [NUM_CH-1:0] bprev, bprev2;
        int tail;
        bprev = '0; bprev2 = '0; tail = -1;
        done_cnt = 0; done_cyc = -1; max_ones = 0; busy_at_done = 1'b1;
        ok_at_done = 'x; err_at_done = 'x;
        for (int i = 0; i < NUM_CH; i++) begin
            rise_cyc[i] = -1; hi_cnt[i] = 0; drop_viol[i] = 0;
            act_at_rise[i] = '0; okv_at_rise[i] = '0;
        end
        for (int c = 1; c <= budget && tail != 0; c++) begin
            @(negedge clk);
            start  = (c == restart_at);
            cfg_wr = (c == cfg_at);
            if (c == cfg_at) begin
                cfg_ch = '0; cfg_lower = cfg_val;
            end
            if ($countones(ch_update) > max_ones) max_ones = $countones(ch_update);
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_update[i]) begin
                    hi_cnt[i]++;
                    if (rise_cyc[i] < 0) begin
                        rise_cyc[i] = c;
                        act_at_rise[i] = {lower_limit[i*FTW_WIDTH +: FTW_WIDTH],
                                          upper_limit[i*FTW_WIDTH +: FTW_WIDTH],
                                          positive_step[i*FTW_WIDTH +: FTW_WIDTH],
                                          positive_rate[i*RATE_WIDTH +: RATE_WIDTH]};
                        okv_at_rise[i] = ch_ok;
                    end
                    if (bprev[i] && !bprev2[i]) drop_viol[i]++;
                end
            end
            bprev2 = bprev; bprev = ch_busy;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = c; ok_at_done = ch_ok; err_at_done = ch_err;
                    busy_at_done = busy; tail = 12;
                end
            end
            if (tail > 0) tail--;
        end
        start = 1'b0; cfg_wr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({ch_update, busy, done} !== '0) begin
            n_err++; $display("FAIL reset_ctl: got %b expected 0", {ch_update, busy, done});
        end
        n_cmp++;
        if ({ch_ok, ch_err} !== '0) begin
            n_err++; $display("FAIL reset_status: got %b expected 0", {ch_ok, ch_err});
        end
        n_cmp++;
        if ({lower_limit, upper_limit, positive_step, positive_rate} !== '0) begin
            n_err++; $display("FAIL reset_bank: got %h expected 0", {lower_limit, upper_limit});
        end
        rst = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_lower[i] = '0; m_upper[i] = '0; m_step[i] = '0; m_rate[i] = '0;
        end
        $display("reset done");
    endtask

    task automatic test_parallel();
        act_t a; stat_t s;
        for (int i = 0; i < NUM_CH; i++) begin
            dly[i] = 2; len[i] = 5; stuck[i] = 0;
            cfg_write(i, 32'h1000_0000 + i, 32'h2000_0000 + 3*i, 32'h0000_0100 + i, 16'(7 + i));
        end
        push_expect(4'b1111, 4'b1111, 4'b0000);
        launch(MODE_PARALLEL, 4'b1111);
        observe(200, 5, -1, '0);
        n_cmp++;
        if (done_cnt !== 1) begin n_err++; $display("FAIL par_done_count: got %0d expected 1", done_cnt); end
        n_cmp++;
        if (busy_at_done !== 1'b0) begin n_err++; $display("FAIL par_busy_at_done: got %b expected 0", busy_at_done); end
        s = sb_stat.pop_front();
        n_cmp++;
        if ({ok_at_done, err_at_done} !== {s.ok, s.err}) begin
            n_err++; $display("FAIL par_status: got ok=%b err=%b expected ok=%b err=%b", ok_at_done, err_at_done, s.ok, s.err);
        end
        while (sb_act.size() > 0) begin
            a = sb_act.pop_front();
            n_cmp++;
            if (act_at_rise[a.ch] !== a.val) begin
                n_err++; $display("FAIL par_active_ch%0d: got %h expected %h", a.ch, act_at_rise[a.ch], a.val);
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            n_cmp++;
            if (rise_cyc[i] < 0 || rise_cyc[i] != rise_cyc[0] || drop_viol[i] != 0) begin
                n_err++; $display("FAIL par_update_ch%0d: got rise=%0d drop_viol=%0d expected rise=%0d drop_viol=0", i, rise_cyc[i], drop_viol[i], rise_cyc[0]);
            end
        end
    endtask

    task automatic test_sequential();
        act_t a; stat_t s;
        for (int i = 0; i < NUM_CH; i++) begin dly[i] = 2; len[i] = 3; end
        push_expect(4'b1010, 4'b1010, 4'b0000);
        launch(MODE_SEQUENTIAL, 4'b1010);
        observe(300, -1, -1, '0);
        n_cmp++;
        if (rise_cyc[0] >= 0 || rise_cyc[2] >= 0) begin
            n_err++; $display("FAIL seq_disabled_quiet: got rise0=%0d rise2=%0d expected -1/-1", rise_cyc[0], rise_cyc[2]);
        end
        n_cmp++;
        if (rise_cyc[1] < 0 || rise_cyc[3] <= rise_cyc[1] || max_ones > 1) begin
            n_err++; $display("FAIL seq_order: got rise1=%0d rise3=%0d max_active=%0d expected ch1 first, then ch3, one at a time", rise_cyc[1], rise_cyc[3], max_ones);
        end
        n_cmp++;
        if (okv_at_rise[3][1] !== 1'b1) begin
            n_err++; $display("FAIL seq_ch1_before_ch3: got ch_ok=%b at ch3 launch expected bit1 set", okv_at_rise[3]);
        end
        n_cmp++;
        if (done_cnt !== 1) begin n_err++; $display("FAIL seq_done_count: got %0d expected 1", done_cnt); end
        s = sb_stat.pop_front();
        n_cmp++;
        if ({ok_at_done, err_at_done} !== {s.ok, s.err}) begin
            n_err++; $display("FAIL seq_status: got ok=%b err=%b expected ok=%b err=%b", ok_at_done, err_at_done, s.ok, s.err);
        end
        while (sb_act.size() > 0) begin
            a = sb_act.pop_front();
            n_cmp++;
            if (act_at_rise[a.ch] !== a.val) begin
                n_err++; $display("FAIL seq_active_ch%0d: got %h expected %h", a.ch, act_at_rise[a.ch], a.val);
            end
        end
    endtask

    task automatic test_timeout();
        act_t a; stat_t s;
        for (int i = 0; i < NUM_CH; i++) begin dly[i] = 2; len[i] = 5; end
        stuck[2] = 1;
        push_expect(4'b1111, 4'b1011, 4'b0100);
        launch(MODE_PARALLEL, 4'b1111);
        observe(300, -1, -1, '0);
        stuck[2] = 0;
        n_cmp++;
        if (hi_cnt[2] != TIMEOUT_CYCLES) begin
            n_err++; $display("FAIL tmo_req_cycles: got %0d expected %0d", hi_cnt[2], TIMEOUT_CYCLES);
        end
        n_cmp++;
        if (done_cnt !== 1) begin n_err++; $display("FAIL tmo_done_count: got %0d expected 1", done_cnt); end
        s = sb_stat.pop_front();
        n_cmp++;
        if ({ok_at_done, err_at_done} !== {s.ok, s.err}) begin
            n_err++; $display("FAIL tmo_status: got ok=%b err=%b expected ok=%b err=%b", ok_at_done, err_at_done, s.ok, s.err);
        end
        while (sb_act.size() > 0) begin
            a = sb_act.pop_front();
            n_cmp++;
            if (act_at_rise[a.ch] !== a.val) begin
                n_err++; $display("FAIL tmo_active_ch%0d: got %h expected %h", a.ch, act_at_rise[a.ch], a.val);
            end
        end
    endtask

    task automatic test_cfg_hold();
        act_t a; stat_t s;
        cfg_write(0, 32'd555383702, 32'd555383703, 32'd10, 16'd3);
        // Run 1: rewrite lower while busy; active must keep the launched value.
        push_expect(4'b0001, 4'b0001, 4'b0000);
        launch(MODE_PARALLEL, 4'b0001);
        observe(200, -1, 4, 32'd1);
        m_lower[0] = 32'd1;
        a = sb_act.pop_front(); s = sb_stat.pop_front();
        n_cmp++;
        if (act_at_rise[0] !== a.val || {ok_at_done, err_at_done} !== {s.ok, s.err}) begin
            n_err++; $display("FAIL cfg_run1: got act=%h ok=%b expected act=%h ok=%b", act_at_rise[0], ok_at_done, a.val, s.ok);
        end
        n_cmp++;
        if (lower_limit[FTW_WIDTH-1:0] !== 32'd555383702) begin
            n_err++; $display("FAIL cfg_hold_after_done: got %0d expected 555383702", lower_limit[FTW_WIDTH-1:0]);
        end
        // Run 2: the shadow write made while busy shows up on the next launch.
        push_expect(4'b0001, 4'b0001, 4'b0000);
        launch(MODE_PARALLEL, 4'b0001);
        observe(200, -1, -1, '0);
        a = sb_act.pop_front(); s = sb_stat.pop_front();
        n_cmp++;
        if (act_at_rise[0] !== a.val) begin
            n_err++; $display("FAIL cfg_run2: got %h expected %h", act_at_rise[0], a.val);
        end
        // Run 3: write and start in the same cycle.
        @(negedge clk);
        cfg_wr = 1'b1; cfg_ch = '0; cfg_lower = 32'd77; m_lower[0] = 32'd77;
        mode = MODE_PARALLEL; ch_enable = 4'b0001; start = 1'b1;
        $display("launch mode=0 en=0001 with same-cycle cfg_wr");
        push_expect(4'b0001, 4'b0001, 4'b0000);
        observe(200, -1, -1, '0);
        a = sb_act.pop_front(); s = sb_stat.pop_front();
        n_cmp++;
        if (act_at_rise[0] !== a.val || {ok_at_done, err_at_done} !== {s.ok, s.err}) begin
            n_err++; $display("FAIL cfg_same_cycle: got act=%h ok=%b expected act=%h ok=%b", act_at_rise[0], ok_at_done, a.val, s.ok);
        end
    endtask

    task automatic test_empty();
        stat_t s;
        push_expect(4'b0000, 4'b0000, 4'b0000);
        launch(MODE_PARALLEL, 4'b0000);
        observe(40, 1, -1, '0);
        s = sb_stat.pop_front();
        n_cmp++;
        if (done_cyc != 2 || done_cnt != 1) begin
            n_err++; $display("FAIL empty_done: got cycle=%0d count=%0d expected cycle=2 count=1", done_cyc, done_cnt);
        end
        n_cmp++;
        if (max_ones != 0 || {ok_at_done, err_at_done} !== {s.ok, s.err}) begin
            n_err++; $display("FAIL empty_quiet: got max_update=%0d ok=%b err=%b expected 0", max_ones, ok_at_done, err_at_done);
        end
    endtask

    task automatic test_reset_mid();
        int waited, dones;
        bit hit;
        for (int i = 0; i < NUM_CH; i++) begin dly[i] = 2; len[i] = 20; end
        launch(MODE_SEQUENTIAL, 4'b1111);
        @(negedge clk);
        start = 1'b0;
        hit = 0;
        for (waited = 0; waited < 50 && !hit; waited++) begin
            if (ch_busy[0]) hit = 1;
            else @(negedge clk);
        end
        n_cmp++;
        if (!hit) begin n_err++; $display("FAIL rstmid_reach_wait: got no busy expected busy within 50 cycles"); end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({ch_update, busy, done, ch_ok, ch_err} !== '0) begin
            n_err++; $display("FAIL rstmid_outputs: got %b expected 0", {ch_update, busy, done, ch_ok, ch_err});
        end
        n_cmp++;
        if ({lower_limit, upper_limit, positive_step, positive_rate} !== '0) begin
            n_err++; $display("FAIL rstmid_bank: got %h expected 0", lower_limit);
        end
        rst = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_lower[i] = '0; m_upper[i] = '0; m_step[i] = '0; m_rate[i] = '0;
        end
        dones = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) dones++;
        end
        n_cmp++;
        if (dones != 0) begin n_err++; $display("FAIL rstmid_no_done: got %0d expected 0", dones); end
        $display("reset mid-sequence checked");
    endtask

    initial begin
        for (int i = 0; i < NUM_CH; i++) begin dly[i] = 2; len[i] = 5; stuck[i] = 0; end
        test_reset();
        test_parallel();
        test_sequential();
        test_timeout();
        test_cfg_hold();
        test_empty();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before 500us");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dds_update_sequencer.md
Name: dds_update_sequencer

Overview:
- Parametrised successor to the fixed four-channel AD9914 power-up update logic. Drives NUM_CH ad9914_ctrl instances.
- Holds per-channel sweep configuration in shadow/active register banks and launches updates in parallel or sequential mode.
- Runs the update/busy handshake per channel, with timeout detection and per-channel status.
- Sits between the top-level work-flow/host logic and the ad9914_ctrl array.

Parameters:
- NUM_CH, 4, number of DDS channels (1..16).
- FTW_WIDTH, 32, width of lower/upper limit and step words.
- RATE_WIDTH, 16, width of the positive_rate word.
- TIMEOUT_CYCLES, 1024, max cycles per handshake phase before a channel is flagged in error (>=2).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- cfg_wr  in  1  one-cycle write strobe into the shadow bank.
- cfg_ch  in  clog2(NUM_CH)  target channel of cfg_wr.
- cfg_lower  in  FTW_WIDTH  lower limit FTW.
- cfg_upper  in  FTW_WIDTH  upper limit FTW.
- cfg_step  in  FTW_WIDTH  positive step.
- cfg_rate  in  RATE_WIDTH  positive rate.
- start  in  1  one-cycle launch request.
- mode  in  1  0 = parallel, 1 = sequential (lowest index first); sampled at start.
- ch_enable  in  NUM_CH  channels to update; sampled at start.
- ch_update  out  NUM_CH  update request to each ad9914_ctrl.
- ch_busy  in  NUM_CH  busy from each ad9914_ctrl.
- lower_limit / upper_limit / positive_step  out  NUM_CH*FTW_WIDTH  active bank, channel i at slice [i*FTW_WIDTH +: FTW_WIDTH].
- positive_rate  out  NUM_CH*RATE_WIDTH  active bank.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse at sequence end.
- ch_ok  out  NUM_CH  channel completed handshake; sticky until next accepted start.
- ch_err  out  NUM_CH  channel timed out; sticky until next accepted start.

Behaviour:
- Reset: all outputs 0; both banks 0; FSM in IDLE; per-channel handshakes in IDLE.
- cfg_wr: writes the shadow bank at cfg_ch on the next edge. Allowed at any time. cfg_ch >= NUM_CH is ignored.
- Launch: when channel i is launched, its shadow entry is copied to the active bank in the same cycle that ch_update[i] rises. Active outputs are therefore stable for the whole handshake.
- Per-channel handshake (sub-module), states CH_IDLE -> CH_REQ -> CH_BUSY -> CH_IDLE:
  - go: ch_update <= 1; enter CH_REQ; counter <= 0.
  - CH_REQ: if ch_busy == 1, ch_update <= 0, enter CH_BUSY, counter <= 0. Otherwise counter++.
  - CH_BUSY: if ch_busy == 0, pulse fin with ok = 1 and return to CH_IDLE. Otherwise counter++.
  - Timeout: in either wait state, counter == TIMEOUT_CYCLES-1 pulses fin with ok = 0, drives ch_update <= 0, and returns to CH_IDLE.
  - Minimum latency from go to fin is 3 cycles when busy is high for exactly 1 cycle.
- Top FSM, states IDLE, PAR_WAIT, SEQ_LAUNCH, SEQ_WAIT, FINISH:
  - IDLE: on start, latch mode and ch_enable, clear ch_ok/ch_err, busy <= 1.
    - If ch_enable == 0, go to FINISH.
    - Else if mode == 0, issue go to all enabled channels and go to PAR_WAIT.
    - Else go to SEQ_LAUNCH.
  - PAR_WAIT: record each fin into ch_ok/ch_err. When every enabled channel has finished, go to FINISH.
  - SEQ_LAUNCH: go to the lowest-index enabled, not-yet-finished channel, then SEQ_WAIT. If no such channel remains, go to FINISH.
  - SEQ_WAIT: on that channel's fin, record status and return to SEQ_LAUNCH.
  - FINISH: done <= 1 for one cycle, busy <= 0, return to IDLE.
- Errors: a timed-out channel does not abort the sequence; remaining channels still run.
- start while busy == 1 is ignored. start and cfg_wr in the same cycle: the write lands in the shadow bank first and is visible to the launch.
- Disabled channels keep ch_update = 0 and ch_ok = ch_err = 0.
- Busy still high at launch: the handshake passes straight through CH_REQ on the next cycle. This is accepted, not treated as an error.
- rst mid-sequence: immediate return to reset state. ch_update drops in the same cycle. No done pulse.

Decomposition:
- Shared package dds_seq_pkg holds the top-FSM and channel-state enums, MODE_PARALLEL/MODE_SEQUENTIAL constants, and the clog2 helper.
- One sub-module, dds_ch_handshake, instantiated NUM_CH times via generate.
- The counter width is clog2(TIMEOUT_CYCLES).

Test Plan:
- Parallel, all 4 enabled, each busy model raises 2 cycles after update for 5 cycles -> ch_update drops the cycle after busy rises; done pulses once; ch_ok = 4'b1111; ch_err = 0.
- Sequential, ch_enable = 4'b1010 -> ch_update[1] asserts first; ch_update[3] only after ch1 fin; ch0/ch2 stay 0; ch_ok = 4'b1010.
- Channel 2 busy stuck low, TIMEOUT_CYCLES = 16 -> ch_update[2] drops after 16 cycles in CH_REQ; ch_err = 4'b0100; others ok; done pulses.
- cfg_wr ch0 lower = 555383702 / upper = 555383703, start, then cfg_wr ch0 lower = 1 while busy -> active lower_limit[0] stays 555383702 until the next start.
- start with ch_enable = 0 -> done pulses 2 cycles later; no ch_update activity. A second start while busy is ignored (single done).
- rst asserted during SEQ_WAIT -> next cycle all outputs 0, busy = 0, no done pulse.
